// File: rtl/cpu_control_unit_if.sv
// cpu_control_unit_if: control-unit <-> datapath/memory signal bundle.
// master = control unit, slave = datapath side.
interface cpu_control_unit_if;
  logic        start;
  logic [31:0] IR;
  logic        mem_ready;
  logic [15:0] reg_in;
  logic [15:0] reg_out;
  logic        PCout;
  logic        Inc_PC;
  logic        IR_in;
  logic        Y_in;
  logic        Z_in;
  logic        HI_in;
  logic        LO_in;
  logic        MAR_in;
  logic        MDR_in;
  logic        read;
  logic        write;
  logic        ZLOWout;
  logic        ZHIout;
  logic        LOout;
  logic        HIout;
  logic        MDRout;
  logic        Cout;
  logic [3:0]  ALU_select;
  logic        run;
  logic        fault;
  logic        illegal;

  modport master (
    input  start, IR, mem_ready,
    output reg_in, reg_out,
    output PCout, Inc_PC, IR_in, Y_in, Z_in,
    output HI_in, LO_in, MAR_in, MDR_in,
    output read, write,
    output ZLOWout, ZHIout, LOout, HIout,
    output MDRout, Cout,
    output ALU_select, run, fault, illegal
  );

  modport slave (
    output start, IR, mem_ready,
    input  reg_in, reg_out,
    input  PCout, Inc_PC, IR_in, Y_in, Z_in,
    input  HI_in, LO_in, MAR_in, MDR_in,
    input  read, write,
    input  ZLOWout, ZHIout, LOout, HIout,
    input  MDRout, Cout,
    input  ALU_select, run, fault, illegal
  );
endinterface

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: one-micro-step-per-clock sequencer for the single-bus datapath.
// Optional CU_SINGLE_STEP_EN adds a step input and a PAUSE state between instructions.
module cpu_control_unit #(
  parameter int MEM_TIMEOUT = 255
) (
  input logic clk,
  input logic clr,
`ifdef CU_SINGLE_STEP_EN
  input logic step,
`endif
  cpu_control_unit_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7,
    S_HALT, S_FAULT, S_PAUSE
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00001;
  localparam logic [4:0] OP_ADDI = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_MUL  = 5'b01000;
  localparam logic [4:0] OP_DIV  = 5'b01001;
  localparam logic [4:0] OP_MFHI = 5'b01010;
  localparam logic [4:0] OP_MFLO = 5'b01011;
  localparam logic [4:0] OP_NOP  = 5'b11000;
  localparam logic [4:0] OP_HALT = 5'b11001;

  localparam logic [15:0] W_TMO_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  state_t      w_done;
  logic [15:0] r_wcnt;
  logic        r_fault;

  logic [4:0]  w_op;
  logic [15:0] w_ra;
  logic [15:0] w_rb;
  logic [15:0] w_rc;
  logic        w_alu;
  logic        w_addi;
  logic        w_ld;
  logic        w_st;
  logic        w_md;
  logic        w_mfhi;
  logic        w_mflo;
  logic        w_halt;
  logic        w_wait;
  logic        w_tmo;

  assign w_op   = bus.IR[31:27];
  assign w_ra   = 16'd1 << bus.IR[26:23];
  assign w_rb   = 16'd1 << bus.IR[22:19];
  assign w_rc   = 16'd1 << bus.IR[18:15];

  assign w_alu  = (w_op == OP_ADD) || (w_op == OP_SUB) ||
                  (w_op == OP_AND) || (w_op == OP_OR);
  assign w_addi = (w_op == OP_ADDI);
  assign w_ld   = (w_op == OP_LD);
  assign w_st   = (w_op == OP_ST);
  assign w_md   = (w_op == OP_MUL) || (w_op == OP_DIV);
  assign w_mfhi = (w_op == OP_MFHI);
  assign w_mflo = (w_op == OP_MFLO);
  assign w_halt = (w_op == OP_HALT);

  assign w_wait = (r_state == S_T1) ||
                  (r_state == S_T6 && w_ld) ||
                  (r_state == S_T7 && w_st);
  assign w_tmo  = (r_wcnt == W_TMO_LAST);

`ifdef CU_SINGLE_STEP_EN
  assign w_done = S_PAUSE;
`else
  assign w_done = S_T0;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      // counter restarts on every entry to a wait step
      if (w_wait && !bus.mem_ready)
        r_wcnt <= r_wcnt + 16'd1;
      else
        r_wcnt <= '0;
      if (w_next == S_FAULT)
        r_fault <= 1'b1;
    end
  end

  assign bus.fault = r_fault;
  assign bus.run   = !(r_state == S_IDLE || r_state == S_HALT ||
                       r_state == S_FAULT || r_state == S_PAUSE);

  always_comb begin
    w_next         = r_state;
    bus.reg_in     = '0;
    bus.reg_out    = '0;
    bus.PCout      = 1'b0;
    bus.Inc_PC     = 1'b0;
    bus.IR_in      = 1'b0;
    bus.Y_in       = 1'b0;
    bus.Z_in       = 1'b0;
    bus.HI_in      = 1'b0;
    bus.LO_in      = 1'b0;
    bus.MAR_in     = 1'b0;
    bus.MDR_in     = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.ZLOWout    = 1'b0;
    bus.ZHIout     = 1'b0;
    bus.LOout      = 1'b0;
    bus.HIout      = 1'b0;
    bus.MDRout     = 1'b0;
    bus.Cout       = 1'b0;
    bus.ALU_select = 4'd0;
    bus.illegal    = 1'b0;

    case (r_state)
      S_IDLE: if (bus.start) w_next = S_T0;
      S_T0: begin
        bus.PCout  = 1'b1;
        bus.MAR_in = 1'b1;
        bus.Inc_PC = 1'b1;
        w_next     = S_T1;
      end
      S_T1: begin
        bus.read = 1'b1;
        if (bus.mem_ready) begin
          bus.MDR_in = 1'b1;
          w_next     = S_T2;
        end else if (w_tmo) begin
          w_next = S_FAULT;
        end
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IR_in  = 1'b1;
        w_next     = S_T3;
      end
      S_T3: begin
        unique case (1'b1)
          w_alu, w_addi, w_ld, w_st: begin
            bus.reg_out = w_rb;
            bus.Y_in    = 1'b1;
            w_next      = S_T4;
          end
          w_md: begin
            bus.reg_out = w_ra;
            bus.Y_in    = 1'b1;
            w_next      = S_T4;
          end
          w_mfhi: begin
            bus.HIout  = 1'b1;
            bus.reg_in = w_ra;
            w_next     = w_done;
          end
          w_mflo: begin
            bus.LOout  = 1'b1;
            bus.reg_in = w_ra;
            w_next     = w_done;
          end
          w_halt: w_next = S_HALT;
          default: begin
            // undefined opcodes flag illegal and fall through as nop
            bus.illegal = (w_op != OP_NOP);
            w_next      = w_done;
          end
        endcase
      end
      S_T4: begin
        unique case (1'b1)
          w_alu: begin
            bus.reg_out    = w_rc;
            bus.ALU_select = 4'(w_op - OP_ADD);
            bus.Z_in       = 1'b1;
            w_next         = S_T5;
          end
          w_addi, w_ld, w_st: begin
            bus.Cout = 1'b1;
            bus.Z_in = 1'b1;
            w_next   = S_T5;
          end
          w_md: begin
            bus.reg_out    = w_rb;
            bus.ALU_select = (w_op == OP_DIV) ? 4'd5 : 4'd4;
            bus.Z_in       = 1'b1;
            w_next         = S_T5;
          end
          default: w_next = w_done;
        endcase
      end
      S_T5: begin
        unique case (1'b1)
          w_alu, w_addi: begin
            bus.ZLOWout = 1'b1;
            bus.reg_in  = w_ra;
            w_next      = w_done;
          end
          w_ld, w_st: begin
            bus.ZLOWout = 1'b1;
            bus.MAR_in  = 1'b1;
            w_next      = S_T6;
          end
          w_md: begin
            bus.ZLOWout = 1'b1;
            bus.LO_in   = 1'b1;
            w_next      = S_T6;
          end
          default: w_next = w_done;
        endcase
      end
      S_T6: begin
        unique case (1'b1)
          w_ld: begin
            bus.read = 1'b1;
            if (bus.mem_ready) begin
              bus.MDR_in = 1'b1;
              w_next     = S_T7;
            end else if (w_tmo) begin
              w_next = S_FAULT;
            end
          end
          w_st: begin
            bus.reg_out = w_ra;
            bus.MDR_in  = 1'b1;
            w_next      = S_T7;
          end
          w_md: begin
            bus.ZHIout = 1'b1;
            bus.HI_in  = 1'b1;
            w_next     = w_done;
          end
          default: w_next = w_done;
        endcase
      end
      S_T7: begin
        unique case (1'b1)
          w_ld: begin
            bus.MDRout = 1'b1;
            bus.reg_in = w_ra;
            w_next     = w_done;
          end
          w_st: begin
            bus.write = 1'b1;
            if (bus.mem_ready)
              w_next = w_done;
            else if (w_tmo)
              w_next = S_FAULT;
          end
          default: w_next = w_done;
        endcase
      end
      S_HALT:  w_next = S_HALT;
      S_FAULT: w_next = S_FAULT;
`ifdef CU_SINGLE_STEP_EN
      S_PAUSE: if (step) w_next = S_T0;
`endif
      default: w_next = S_IDLE;
    endcase
  end

endmodule
